bcd_signo_serial: RTL and testbench

//   Sequential signed-binary to sign+BCD converter (shift-add-3 / double dabble).

---
 rtl/bcd_signo_serial.sv | 101 ++++++++++
 tb/tb_bcd_signo_serial.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_signo_serial.sv
// Signed two's-complement to sign + BCD converter.
// Uses a serial shift-add-3 (double dabble) loop, one input bit per clock.
// The bcd and signo outputs are registered and change only when a conversion
// completes or on reset. The display scanner therefore never sees a partial value.
module bcd_signo_serial #(
    parameter int IN_W = 9,
    parameter int ND   = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [IN_W-1:0] resultado,
    output logic            busy,
    output logic            done,
    output logic            signo,
    output logic [4*ND-1:0] bcd
);

    localparam int CW = $clog2(IN_W + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // cnt_reg holds this value during the final shift iteration.
    localparam logic [CW-1:0] LAST_ITER = CW'(IN_W - 1);

    logic [1:0]      state_reg;
    logic [IN_W-1:0] mag_reg;
    logic [4*ND-1:0] scratch_reg;
    logic [4*ND-1:0] adj;
    logic [CW-1:0]   cnt_reg;
    logic            signo_int_reg;

    // Add 3 to every BCD nibble that is 5 or more. All nibbles are
    // adjusted in parallel before each shift.
    genvar gi;
    generate
        for (gi = 0; gi < ND; gi++) begin : g_adj
            assign adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                  ? scratch_reg[4*gi +: 4] + 4'd3
                                  : scratch_reg[4*gi +: 4];
        end
    endgenerate

    // Conversion FSM: IDLE accepts a value, SHIFT runs IN_W iterations,
    // and DONE publishes the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            mag_reg       <= '0;
            scratch_reg   <= '0;
            cnt_reg       <= '0;
            signo_int_reg <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            signo         <= 1'b0;
            bcd           <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        signo_int_reg <= resultado[IN_W-1];
                        // Negating the most negative value gives 2^(IN_W-1).
                        // Read as unsigned, that is exactly the magnitude.
                        mag_reg       <= resultado[IN_W-1] ? -resultado : resultado;
                        scratch_reg   <= '0;
                        cnt_reg       <= '0;
                        busy          <= 1'b1;
                        state_reg     <= SHIFT;
                    end
                end
                SHIFT: begin
                    // {scratch, mag} acts as a circular shift register.
                    // The bit that wraps into mag is always 0 because
                    // 10^ND > 2^(IN_W-1), and it lands in a position
                    // that is never consumed.
                    scratch_reg <= {adj[4*ND-2:0], mag_reg[IN_W-1]};
                    mag_reg     <= {mag_reg[IN_W-2:0], adj[4*ND-1]};
                    cnt_reg     <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST_ITER) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    bcd       <= scratch_reg;
                    signo     <= signo_int_reg;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_signo_serial.sv
// Testbench for bcd_signo_serial.
// A reference model predicts the sign and decimal digits of each accepted
// conversion with plain integer arithmetic, along with the cycle in which
// done must appear. A separate monitor checks the DUT against those predictions.
module tb_bcd_signo_serial;

    localparam int IN_W = 9;
    localparam int ND   = 3;

    logic            clk;
    logic            rst;
    logic            start;
    logic [IN_W-1:0] resultado;
    logic            busy;
    logic            done;
    logic            signo;
    logic [4*ND-1:0] bcd;

    bcd_signo_serial #(.IN_W(IN_W), .ND(ND)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .resultado (resultado),
        .busy      (busy),
        .done      (done),
        .signo     (signo),
        .bcd       (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            s;
        logic [4*ND-1:0] b;
        int              due;
    } exp_t;

    exp_t            sb_q[$];
    int              cyc = 0;
    int              last_k = -1000;
    int              next_ok = 0;
    logic            held_s = 1'b0;
    logic [4*ND-1:0] held_b = '0;
    int              pass_cnt = 0;
    int              total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference: interpret the input as a signed integer, then split its magnitude into decimal digits.
    function automatic exp_t ref_conv(input logic [IN_W-1:0] r, input int due);
        exp_t e;
        int   v;
        int   m;
        int   p;
        v = r[IN_W-1] ? int'(r) - (1 << IN_W) : int'(r);
        m = (v < 0) ? -v : v;
        e.s = (v < 0);
        e.b = '0;
        p = 1;
        for (int d = 0; d < ND; d++) begin
            e.b[4*d +: 4] = 4'((m / p) % 10);
            p = p * 10;
        end
        e.due = due;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Model: accept start when idle, expect done IN_W+1 edges later, and ignore start while busy.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_q.delete();
            last_k  = -1000;
            next_ok = 0;
            held_s  = 1'b0;
            held_b  = '0;
        end else begin
            if (start && (cyc + 1 >= next_ok)) begin
                sb_q.push_back(ref_conv(resultado, cyc + 1 + IN_W + 1));
                last_k  = cyc + 1;
                next_ok = cyc + 1 + IN_W + 2;
            end
        end
    end

    // Monitor: every falling edge, compare the outputs with the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_signo", 32'(signo), 32'd0);
            chk("rst_bcd", 32'(bcd), 32'd0);
        end else begin
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_done", 32'(done), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.due));
                    chk("signo", 32'(signo), 32'(e.s));
                    chk("bcd", 32'(bcd), 32'(e.b));
                    held_s = e.s;
                    held_b = e.b;
                end
            end else begin
                if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                    e = sb_q.pop_front();
                    chk("missing_done", 32'(done), 32'd1);
                    held_s = e.s;
                    held_b = e.b;
                end
                chk("hold_signo", 32'(signo), 32'(held_s));
                chk("hold_bcd", 32'(bcd), 32'(held_b));
            end
            chk("busy", 32'(busy), 32'((cyc - last_k >= 0) && (cyc - last_k <= IN_W)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic convert(input logic [IN_W-1:0] v);
        start     = 1'b1;
        resultado = v;
        tick();
        start     = 1'b0;
        resultado = IN_W'($urandom);
        repeat (12) tick();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        resultado = '0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Directed corner values.
        convert(9'h0FF);
        convert(9'h100);
        convert(9'h1FF);
        convert(9'h000);
        convert(9'h07B);
        convert(9'h001);

        // Hold start high while resultado changes every cycle.
        start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            resultado = IN_W'($urandom);
            tick();
        end
        start = 1'b0;
        repeat (12) tick();

        // Reset in the middle of a conversion, then convert again.
        convert(9'h0FF);
        start = 1'b1;
        resultado = 9'h1A1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        convert(9'h1A1);

        // Random start pulses, including pulses that arrive while busy.
        for (int i = 0; i < 1500; i++) begin
            start     = ($urandom_range(0, 2) == 0);
            resultado = IN_W'($urandom);
            tick();
        end
        start = 1'b0;
        repeat (15) tick();

        chk("pending_results", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
